// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t         : controller states (IDLE, CALC, DONE)
//   booth_digit_t   : recoded Booth digit as {neg, one, two}
//   booth_ext_width : operand width after sign/zero extension (N+2)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // one: |digit| == 1, two: |digit| == 2, neg: digit is negative
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Two extra bits let a signed Booth datapath cover the full unsigned range
    // and keep the odd-width window alignment for the last digit.
    function automatic int booth_ext_width(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit recoder and partial-product generator (combinational).
// Ports:
//   window       [2:0]  multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   multiplicand [W-1:0] extended two's-complement multiplicand
//   partial      [W:0]   signed partial product: 0, +/-A or +/-2A
module booth_r4_digit
    import mult_pkg::*;
#(
    parameter int W = 34
) (
    input  logic [2:0]   window,
    input  logic [W-1:0] multiplicand,
    output logic [W:0]   partial
);

    booth_digit_t digit;
    logic [W:0]   a_sx;
    logic [W:0]   mag;

    always_comb begin
        digit.one = window[0] ^ window[1];
        digit.two = (window == 3'b011) || (window == 3'b100);
        // 3'b111 is a zero digit; keep neg clear so the product is a clean zero.
        digit.neg = window[2] & ~(window[1] & window[0]);

        a_sx = {multiplicand[W-1], multiplicand};

        if (digit.two) begin
            mag = a_sx << 1;
        end else if (digit.one) begin
            mag = a_sx;
        end else begin
            mag = '0;
        end

        partial = digit.neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Iterative signed/unsigned multiplier using radix-4 Booth recoding,
// one partial product per clock.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   start        request a multiply (honoured only while idle)
//   signed_mode  1: two's complement operands, 0: unsigned (sampled with start)
//   inputA       multiplicand (sampled with start)
//   inputB       multiplier (sampled with start)
//   busy         high while an operation is in CALC or DONE
//   done         one-cycle pulse; result is valid from this cycle onward
//   result       2N-bit product, held until the next operation completes
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// CALC  | one Booth digit accumulated per cycle, K cycles total
// DONE  | product complete; result and done are registered on the exit edge
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   inputA,
    input  logic [N-1:0]   inputB,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
);

    localparam int W     = booth_ext_width(N);
    localparam int K     = N / 2 + 1;
    localparam int ACC_W = 2 * N + 4;
    localparam int CNT_W = $clog2(K + 1);

    state_t state, state_nxt;

    logic [W-1:0]     a_reg;
    // Multiplier with the implicit b[-1]=0 appended; shifted right two bits per
    // step so the current Booth window is always b_reg[2:0].
    logic [W:0]       b_reg;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;

    logic [W-1:0]     a_ext;
    logic [W-1:0]     b_ext;
    logic [W:0]       pp;
    logic [ACC_W-1:0] pp_ext;
    logic [ACC_W-1:0] pp_sh;
    logic             last_step;

    always_comb begin
        if (signed_mode) begin
            a_ext = {{2{inputA[N-1]}}, inputA};
            b_ext = {{2{inputB[N-1]}}, inputB};
        end else begin
            a_ext = {2'b00, inputA};
            b_ext = {2'b00, inputB};
        end
    end

    booth_r4_digit #(
        .W (W)
    ) u_digit (
        .window       (b_reg[2:0]),
        .multiplicand (a_reg),
        .partial      (pp)
    );

    assign pp_ext    = {{(ACC_W - W - 1){pp[W]}}, pp};
    assign pp_sh     = pp_ext << {count, 1'b0};
    assign last_step = (count == CNT_W'(K - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            count  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_ext;
                        b_reg <= {b_ext, 1'b0};
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc + pp_sh;
                    b_reg <= {{2{b_reg[W]}}, b_reg[W:2]};
                    count <= count + 1'b1;
                end
                DONE: begin
                    result <= acc[2*N-1:0];
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mult.sv
module tb_seq_booth_mult;

    localparam int N = 32;
    localparam int K = N / 2 + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   inputA;
    logic [N-1:0]   inputB;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;

    seq_booth_mult #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .inputA      (inputA),
        .inputB      (inputB),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0] res;
        int             due;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   prev_done = 1'b0;

    // Monitor: pops the scoreboard whenever the DUT pulses done.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (done) begin
            if (prev_done) begin
                checks++;
                errors++;
                $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cycle %0d result=%h, required no done", cyc, result);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL %s latency: done at cycle %0d, required %0d", e.name, cyc, e.due);
                end
            end
        end
        prev_done = done;
    end

    task automatic chk(input string nm, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sm, input bit expect_done, input logic [2*N-1:0] exp);
        int budget = 0;
        @(negedge clk);
        while (busy && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s idle_wait: busy still %b after %0d cycles, required 0", nm, busy, budget);
        end
        signed_mode = sm;
        inputA      = a;
        inputB      = b;
        start       = 1'b1;
        // start is sampled at the next edge E0; done follows edge E(K+1).
        if (expect_done) sb.push_back('{exp, cyc + K + 2, nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain: %0d results outstanding, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        inputA      = '0;
        inputB      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy",   {63'd0, busy}, 64'd0);
        chk("reset_done",   {63'd0, done}, 64'd0);
        chk("reset_result", result,        64'd0);

        // Idle period: the monitor flags any stray done.
        repeat (10) @(negedge clk);

        // Signed basics
        issue("s_m3x5",   32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1);
        issue("s_m1x2",   32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE);
        // Unsigned extremes
        issue("u_maxsq",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE00000001);
        issue("u_maxx2",  32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, 64'h00000001FFFFFFFE);
        issue("u_msbx2",  32'h80000000, 32'd2, 1'b0, 1'b1, 64'h0000000100000000);
        // Signed corners
        issue("s_minsq",  32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000);
        issue("s_minmax", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 64'hC000000080000000);
        drain("basics");

        // Start while busy is ignored; changed operands do not disturb the op.
        issue("hs_7x6", 32'd7, 32'd6, 1'b0, 1'b1, 64'd42);
        repeat (3) @(negedge clk);
        inputA = 32'd1;
        inputB = 32'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        inputA = 32'hDEADBEEF;
        signed_mode = 1'b1;
        drain("hs_7x6");
        chk("hs_held_result", result, 64'd42);

        // Start in the cycle after done is accepted.
        @(posedge clk);
        issue("after_done", 32'd9, 32'd11, 1'b0, 1'b1, 64'd99);
        drain("after_done");

        // Reset mid-operation aborts with no done.
        issue("rst_mid", 32'd100, 32'd100, 1'b0, 1'b0, 64'd0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_result", result,        64'd0);
        chk("rst_mid_busy",   {63'd0, busy}, 64'd0);
        chk("rst_mid_done",   {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (K + 4) @(negedge clk);
        chk("rst_mid_no_result", result, 64'd0);

        issue("post_rst_3x4", 32'd3, 32'd4, 1'b0, 1'b1, 64'd12);
        drain("post_rst");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
